// File: rtl/imm_pack_pkg.sv
// Shared definitions for the immediate packer and its matching extender.
// Extender-mode codes, candidate-flag bundle and the reference extend function.
package imm_pack_pkg;

  localparam logic [1:0] EOP_SIGN   = 2'b00;
  localparam logic [1:0] EOP_ZERO   = 2'b01;
  localparam logic [1:0] EOP_UPPER  = 2'b10;
  localparam logic [1:0] EOP_SHIFT2 = 2'b11;

  typedef struct packed {
    logic sign;
    logic zero;
    logic upper;
    logic shift2;
  } cand_t;

  // Rebuilds the 32-bit constant from an immediate exactly as the extender does.
  function automatic logic [31:0] immExtend(input logic [15:0] imm, input logic [1:0] eop);
    logic [31:0] result;
    case (eop)
      EOP_SIGN:   result = {{16{imm[15]}}, imm};
      EOP_ZERO:   result = {16'h0000, imm};
      EOP_UPPER:  result = {imm, 16'h0000};
      default:    result = {{14{imm[15]}}, imm, 2'b00};
    endcase
    return result;
  endfunction

endpackage

// File: rtl/imm_pack_classify.sv
// Combinational candidate detection (for stage 1) and fixed-priority selection
// (for stage 2) of the 16-bit immediate encoding.
module imm_pack_classify
  import imm_pack_pkg::*;
(
  input  logic [31:0] i_detValue,
  output cand_t       o_cand,
  input  logic [31:0] i_selValue,
  input  cand_t       i_selCand,
  output logic [15:0] o_imm,
  output logic [1:0]  o_eop,
  output logic        o_ok
);

  logic w_signFit;
  logic w_shiftHighFit;

  assign w_signFit      = (&i_detValue[31:15]) || ~(|i_detValue[31:15]);
  assign w_shiftHighFit = (&i_detValue[31:17]) || ~(|i_detValue[31:17]);

  assign o_cand.sign   = w_signFit;
  assign o_cand.zero   = (i_detValue[31:16] == 16'h0000);
  assign o_cand.upper  = (i_detValue[15:0] == 16'h0000);
  assign o_cand.shift2 = (i_detValue[1:0] == 2'b00) && w_shiftHighFit;

  // Priority SIGN > ZERO > UPPER > SHIFT2; nothing fits -> all-zero, not ok.
  always_comb begin
    o_imm = 16'h0000;
    o_eop = EOP_SIGN;
    o_ok  = 1'b0;
    if (i_selCand.sign) begin
      o_imm = i_selValue[15:0];
      o_eop = EOP_SIGN;
      o_ok  = 1'b1;
    end else if (i_selCand.zero) begin
      o_imm = i_selValue[15:0];
      o_eop = EOP_ZERO;
      o_ok  = 1'b1;
    end else if (i_selCand.upper) begin
      o_imm = i_selValue[31:16];
      o_eop = EOP_UPPER;
      o_ok  = 1'b1;
    end else if (i_selCand.shift2) begin
      o_imm = i_selValue[17:2];
      o_eop = EOP_SHIFT2;
      o_ok  = 1'b1;
    end
  end

endmodule

// File: rtl/imm_pack.sv
// Two-stage valid/ready pipeline packing a 32-bit constant into imm + extender mode.
// Define IMM_PACK_STATS_EN to add saturating transfer/failure counters.
module imm_pack
  import imm_pack_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic [1:0]  out_eop,
  output logic        out_ok
`ifdef IMM_PACK_STATS_EN
  ,
  output logic [15:0] cnt_total,
  output logic [15:0] cnt_fail
`endif
);

  logic        r_s1Valid;
  logic [31:0] r_s1Value;
  cand_t       r_s1Cand;
  logic        r_s2Valid;
  logic [15:0] r_imm;
  logic [1:0]  r_eop;
  logic        r_ok;

  cand_t       w_cand;
  logic [15:0] w_selImm;
  logic [1:0]  w_selEop;
  logic        w_selOk;
  logic        w_s2Free;

  imm_pack_classify u_classify (
    .i_detValue (in_value),
    .o_cand     (w_cand),
    .i_selValue (r_s1Value),
    .i_selCand  (r_s1Cand),
    .o_imm      (w_selImm),
    .o_eop      (w_selEop),
    .o_ok       (w_selOk)
  );

  // Stage 2 can take new data when empty or draining this cycle.
  assign w_s2Free = !r_s2Valid || out_ready;
  assign in_ready = !r_s1Valid || w_s2Free;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
      r_s1Value <= 32'h0;
      r_s1Cand  <= '0;
    end else if (in_ready) begin
      r_s1Valid <= in_valid;
      if (in_valid) begin
        r_s1Value <= in_value;
        r_s1Cand  <= w_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2Valid <= 1'b0;
      r_imm     <= 16'h0;
      r_eop     <= EOP_SIGN;
      r_ok      <= 1'b0;
    end else if (w_s2Free) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_imm <= w_selImm;
        r_eop <= w_selEop;
        r_ok  <= w_selOk;
      end
    end
  end

  assign out_valid = r_s2Valid;
  assign out_imm   = r_imm;
  assign out_eop   = r_eop;
  assign out_ok    = r_ok;

`ifdef IMM_PACK_STATS_EN
  logic        w_outFire;
  logic [15:0] r_cntTotal;
  logic [15:0] r_cntFail;

  assign w_outFire = r_s2Valid && out_ready;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cntTotal <= 16'h0;
      r_cntFail  <= 16'h0;
    end else if (w_outFire) begin
      if (r_cntTotal != 16'hFFFF) r_cntTotal <= r_cntTotal + 16'h1;
      if (!r_ok && (r_cntFail != 16'hFFFF)) r_cntFail <= r_cntFail + 16'h1;
    end
  end

  assign cnt_total = r_cntTotal;
  assign cnt_fail  = r_cntFail;
`endif

endmodule
